// File: rtl/seq_1101_framer.sv
// Serial frame transmitter: SYNC word then payload MSB first on one bit line.
// Define FRAMER_PARITY_EN to append an even-parity bit after the payload.
module seq_1101_framer #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC     = 4'b1101,
  parameter int                IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

`ifdef FRAMER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int M1   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAXC = (M1 > IDLE_GAP) ? M1 : IDLE_GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_PAR, ST_GAP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] sh;
  logic              out_n, out_valid_n, frame_done_n;
  logic              hs, last_bit;

  // frame_done marks the bit on the line that ends the frame
  assign din_ready = ~rst & ((state == ST_IDLE) | ((IDLE_GAP == 0) & frame_done));
  assign hs        = din_valid & din_ready;
  assign last_bit  = (state == ST_PAR) | ((state == ST_DATA) & (cnt == '0) & !PAR_EN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sh         <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      if (hs) sh <= din;
      out        <= out_n;
      out_valid  <= out_valid_n;
      busy       <= out_valid_n;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: if (hs) begin
        state_n = ST_SYNC;
        cnt_n   = CW'(SYNC_W - 1);
      end
      ST_SYNC: if (cnt == '0) begin
        state_n = ST_DATA;
        cnt_n   = CW'(DATA_W - 1);
      end else begin
        cnt_n = cnt - CW'(1);
      end
      ST_DATA: if (cnt != '0) cnt_n = cnt - CW'(1);
               else if (PAR_EN) state_n = ST_PAR;
      ST_PAR:  state_n = ST_PAR;
      ST_GAP:  if (cnt == '0) state_n = ST_IDLE;
               else cnt_n = cnt - CW'(1);
      default: state_n = ST_IDLE;
    endcase
    // end of frame: gap, or chain straight into the next SYNC when gapless
    if (last_bit) begin
      if (IDLE_GAP > 0) begin
        state_n = ST_GAP;
        cnt_n   = CW'(IDLE_GAP - 1);
      end else if (hs) begin
        state_n = ST_SYNC;
        cnt_n   = CW'(SYNC_W - 1);
      end else begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    end
  end

  // decoded from the next state so every output comes straight from a flop
  always_comb begin
    out_n        = 1'b0;
    out_valid_n  = 1'b0;
    frame_done_n = 1'b0;
    case (state_n)
      ST_SYNC: begin
        out_valid_n = 1'b1;
        for (int unsigned i = 0; i < SYNC_W; i++)
          if (cnt_n == CW'(i)) out_n = SYNC[i];
      end
      ST_DATA: begin
        out_valid_n = 1'b1;
        for (int unsigned i = 0; i < DATA_W; i++)
          if (cnt_n == CW'(i)) out_n = sh[i];
        frame_done_n = (cnt_n == '0) & !PAR_EN;
      end
      ST_PAR: begin
        out_valid_n  = 1'b1;
        out_n        = ^sh;
        frame_done_n = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_1101_framer.sv
// Bench for seq_1101_framer: three instances (IDLE_GAP 1, 0, 2) checked against a bit-queue model.
module tb_seq_1101_framer;

  localparam int GAPS [3] = '{1, 0, 2};
  localparam logic [3:0] SYNCV = 4'b1101;
`ifdef FRAMER_PARITY_EN
  localparam int L = 13;
  localparam logic [31:0] EXP_A5  = {19'd0, 4'hD, 8'hA5, 1'b0};
  localparam logic [31:0] EXP_01  = {19'd0, 4'hD, 8'h01, 1'b1};
  localparam logic [31:0] EXP_3C  = {19'd0, 4'hD, 8'h3C, 1'b0};
  localparam logic [31:0] EXP_B2B = {6'd0, 4'hD, 8'hA5, 1'b0, 4'hD, 8'h3C, 1'b0};
`else
  localparam int L = 12;
  localparam logic [31:0] EXP_A5  = {20'd0, 4'hD, 8'hA5};
  localparam logic [31:0] EXP_01  = {20'd0, 4'hD, 8'h01};
  localparam logic [31:0] EXP_3C  = {20'd0, 4'hD, 8'h3C};
  localparam logic [31:0] EXP_B2B = {8'd0, 4'hD, 8'hA5, 4'hD, 8'h3C};
`endif

  logic       clk, rst;
  logic [7:0] din [3];
  logic       dv [3];
  logic       rdy [3], out_s [3], ov [3], bz [3], fd [3];

  int n_checks = 0;
  int n_fail   = 0;

  seq_1101_framer #(.DATA_W(8), .SYNC_W(4), .SYNC(4'b1101), .IDLE_GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
    .out(out_s[0]), .out_valid(ov[0]), .busy(bz[0]), .frame_done(fd[0]));
  seq_1101_framer #(.DATA_W(8), .SYNC_W(4), .SYNC(4'b1101), .IDLE_GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
    .out(out_s[1]), .out_valid(ov[1]), .busy(bz[1]), .frame_done(fd[1]));
  seq_1101_framer #(.DATA_W(8), .SYNC_W(4), .SYNC(4'b1101), .IDLE_GAP(2)) dut_g2 (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
    .out(out_s[2]), .out_valid(ov[2]), .busy(bz[2]), .frame_done(fd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of frame bits still to appear; head is the bit on the line now.
  bit mq [3][$];
  int mgap [3];

  function automatic bit mready(input int k);
    return !rst && ((mq[k].size() == 0 && mgap[k] == 0) ||
                    (GAPS[k] == 0 && mq[k].size() == 1));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        mq[k].delete();
        mgap[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit hsm;
        logic [7:0] d;
        hsm = dv[k] && mready(k);
        d = din[k];
        if (mq[k].size() > 0) begin
          void'(mq[k].pop_front());
          if (mq[k].size() == 0) mgap[k] = GAPS[k];
        end else if (mgap[k] > 0) begin
          mgap[k]--;
        end
        if (hsm) begin
          for (int i = 3; i >= 0; i--) mq[k].push_back(SYNCV[i]);
          for (int i = 7; i >= 0; i--) mq[k].push_back(d[i]);
`ifdef FRAMER_PARITY_EN
          mq[k].push_back(^d);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit ev, eo, ed;
      ev = mq[k].size() > 0;
      eo = ev ? mq[k][0] : 1'b0;
      ed = mq[k].size() == 1;
      chk($sformatf("cmp%0d_out", k), 32'(out_s[k]), 32'(eo));
      chk($sformatf("cmp%0d_out_valid", k), 32'(ov[k]), 32'(ev));
      chk($sformatf("cmp%0d_busy", k), 32'(bz[k]), 32'(ev));
      chk($sformatf("cmp%0d_frame_done", k), 32'(fd[k]), 32'(ed));
      chk($sformatf("cmp%0d_din_ready", k), 32'(rdy[k]), 32'(mready(k)));
    end
  end

  task automatic send(input int k, input logic [7:0] d);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    din[k] = d;
    dv[k]  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[k] && n < 60);
    if (!rdy[k]) chk($sformatf("send%0d_accept_timeout", k), 32'(rdy[k]), 32'd1);
    @(posedge clk);
    #1;
    dv[k] = 1'b0;
  endtask

  task automatic capture(input int k, output logic [31:0] bits, output int len,
                         output logic [31:0] fdm, output logic [31:0] rdym, output int w);
    bits = '0; fdm = '0; rdym = '0; len = 0; w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!ov[k] && w < 60);
    if (!ov[k]) chk($sformatf("capture%0d_start_timeout", k), 32'(ov[k]), 32'd1);
    while (ov[k] && len < 32) begin
      bits      = {bits[30:0], out_s[k]};
      fdm[len]  = fd[k];
      rdym[len] = rdy[k];
      len++;
      @(negedge clk);
    end
  endtask

  logic [31:0] b, fdm, rdym, b2, fdm2, rdym2, det;
  int          len, w, len2, w2;
  logic [3:0]  s;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dv[k]  = 1'b0;
      din[k] = 8'h00;
    end
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_out", 32'(out_s[0]), 32'd0);
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_busy", 32'(bz[0]), 32'd0);
    chk("reset_frame_done", 32'(fd[0]), 32'd0);
    chk("reset_din_ready", 32'(rdy[0]), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdy[0]), 32'd1);

    // single frame, default gap
    fork
      send(0, 8'hA5);
      capture(0, b, len, fdm, rdym, w);
    join
    chk("t1_len", 32'(len), 32'(L));
    chk("t1_bits", b, EXP_A5);
    chk("t1_done_pos", fdm, 32'd1 << (L - 1));
    chk("t1_ready_in_frame", rdym, 32'd0);
    chk("t1_gap_out", 32'(out_s[0]), 32'd0);
    chk("t1_gap_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("t1_ready_back", 32'(rdy[0]), 32'd1);

    // loopback into an overlapping 1101 detector
    s = '0; det = '0;
    for (int i = 0; i < len; i++) begin
      s = {s[2:0], b[len-1-i]};
      det[i] = (s == 4'b1101);
    end
    chk("t6_detect_positions", det, 32'h48);

    // back-to-back, IDLE_GAP=0
    fork
      begin
        send(1, 8'hA5);
        send(1, 8'h3C);
      end
      capture(1, b, len, fdm, rdym, w);
    join
    chk("t2_len", 32'(len), 32'(2 * L));
    chk("t2_bits", b, EXP_B2B);
    chk("t2_done_pos", fdm, (32'd1 << (L - 1)) | (32'd1 << (2 * L - 1)));
    chk("t2_ready_pos", rdym & ((32'd1 << (2 * L - 1)) - 32'd1), 32'd1 << (L - 1));

    // IDLE_GAP=2, next word pending during the gap
    fork
      begin
        send(2, 8'hA5);
        send(2, 8'h3C);
      end
      begin
        capture(2, b, len, fdm, rdym, w);
        chk("t3_first_bits", b, EXP_A5);
        chk("t3_gap1_ready", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        chk("t3_gap2_ready", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        chk("t3_idle_ready", 32'(rdy[2]), 32'd1);
        capture(2, b2, len2, fdm2, rdym2, w2);
        chk("t3_next_start", 32'(w2), 32'd1);
        chk("t3_second_bits", b2, EXP_3C);
        chk("t3_second_len", 32'(len2), 32'(L));
      end
    join

    // reset on SYNC bit 3, then a clean frame
    send(0, 8'hA5);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t4_bit3_valid", 32'(ov[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_rst_out", 32'(out_s[0]), 32'd0);
    chk("t4_rst_valid", 32'(ov[0]), 32'd0);
    chk("t4_rst_busy", 32'(bz[0]), 32'd0);
    chk("t4_rst_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_release", 32'(rdy[0]), 32'd1);
    fork
      send(0, 8'h01);
      capture(0, b, len, fdm, rdym, w);
    join
    chk("t4_len", 32'(len), 32'(L));
    chk("t4_bits", b, EXP_01);
    chk("t4_done_pos", fdm, 32'd1 << (L - 1));

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
